mux_pipe_n: RTL and testbench
=============================

Name: mux_pipe_n

Overview:
- Parametrised N:1 select multiplexer with a registered, flow-controlled output stage.
- Generalises the 5-bit 2:1 datapath select mux used for register-address and write-back selection.
- Two modes:
  - Explicit select (MODE=0).
  - Round-robin arbitration among valid requesters (MODE=1).
- Intended for multi-source write-back and operand-forwarding paths in the pipelined processor.

Parameters:
- WIDTH, 5: data width per channel in bits.
- NUM_IN, 4: number of input channels, legal range 2..16.
- SEL_W, 2: select/source-index width; must equal ceil(log2(NUM_IN)).
- MODE, 0: 0 = explicit select via sel; 1 = round-robin arbitration, sel ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational); at most one bit high.
- sel  input  SEL_W  channel select, used in MODE=0 only.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer rr_ptr=0.
  - Assertion mid-transfer discards the held beat immediately, with no partial output.
  - No in_ready is high while rst_n=0.
- Stage capacity:
  - One output register.
  - can_accept = !out_valid || out_ready, so a simultaneous drain and refill in the same cycle is allowed.
- Grant logic is combinational:
  - MODE=0: grant = sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
  - MODE=1: grant = first k with in_valid[k]=1, scanning from rr_ptr upward modulo NUM_IN; no grant when in_valid is all zero.
- Ready: in_ready[grant] = can_accept; all other in_ready bits are 0.
  - In MODE=0, in_ready[sel] = can_accept even when in_valid[sel]=0, for sel < NUM_IN.
- Transfer: when a grant exists and can_accept=1, on the next rising edge:
  - out_data <= channel data.
  - out_src <= grant.
  - out_valid <= 1.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat per cycle while out_ready=1.
- Drain without refill: out_valid && out_ready with no grant -> out_valid <= 0. out_data and out_src hold their last values.
- Stall: while out_valid=1 and out_ready=0, out_data and out_src are stable and every in_ready is 0.
- Pointer update (MODE=1): rr_ptr <= (grant+1) mod NUM_IN, only on an accepted transfer. The pointer holds during stalls and idle cycles.
  - Wrap-around: grant = NUM_IN-1 -> rr_ptr = 0.
- Fairness (MODE=1): any channel that keeps its valid asserted is served within NUM_IN accepted transfers.
- Out-of-range select (MODE=0, sel >= NUM_IN, only possible when NUM_IN is not a power of 2): no transfer; in_ready is all 0.
- sel changes take effect the same cycle; the already-registered output is unaffected.
- No arithmetic beyond the modulo-NUM_IN pointer increment; data passes unmodified.

Test Plan:
1. MODE=0, WIDTH=5, NUM_IN=2, out_ready=1. in_data = {10001, 01110}, both valid.
   - sel=0 -> next cycle out_data=01110, out_src=0, out_valid=1.
   - sel=1 -> out_data=10001, out_src=1.
   - Swap the channel data and repeat -> outputs swap accordingly.
2. Backpressure: transfer 01110, then hold out_ready=0 for 3 cycles while changing sel and data.
   - out_data stays 01110 and out_valid stays 1; in_ready=00.
   - Raise out_ready -> new beat appears the cycle after.
3. Back-to-back throughput: out_ready=1, sel fixed at 1, channel data 00001, 00010, 00011 on consecutive cycles.
   - out_data shows 00001, 00010, 00011 on the following three cycles, with no bubbles.
4. MODE=1, NUM_IN=4, all four valid, out_ready=1 -> out_src sequence 0, 1, 2, 3, 0 (pointer wraps).
   - Then only channels 1 and 3 valid -> out_src alternates 1, 3, 1.
5. MODE=1 stall fairness: all valid, out_ready=0 for 2 cycles after out_src=2 is registered -> rr_ptr stays 3; after release, the next out_src=3.
6. Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and stalled.
   - out_valid, out_data and out_src go to 0 immediately, without waiting for a clock edge.
   - After release, the first MODE=1 grant goes to channel 0.

Source files
------------

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N:1 select mux with a single registered, valid/ready output stage.
// MODE=0 picks the channel named by sel; MODE=1 round-robins over valid channels.
// Data passes through unmodified; out_src records which channel produced it.
module mux_pipe_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] LP_N   = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W:0] LP_ONE = (SEL_W+1)'(1);

  logic [NUM_IN-1:0][WIDTH-1:0] w_ch;
  logic [NUM_IN-1:0]            w_pick_sel;
  logic [NUM_IN-1:0]            w_pick_rr;
  logic [NUM_IN-1:0]            w_pick;
  logic                         w_can_accept;
  logic                         w_gnt_vld;
  logic                         w_xfer;
  logic [SEL_W-1:0]             w_gnt_idx;
  logic [SEL_W-1:0]             w_rr_idx;
  logic                         w_rr_vld;
  logic [SEL_W:0]               w_scan_idx;
  logic [SEL_W:0]               w_ptr_inc;
  logic [SEL_W-1:0]             w_ptr_nxt;
  logic [WIDTH-1:0]             w_mux_data;

  logic [WIDTH-1:0]             r_out_data;
  logic [SEL_W-1:0]             r_out_src;
  logic                         r_out_valid;
  logic [SEL_W-1:0]             r_rr_ptr;

  assign w_ch = in_data;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_can_accept = rst_n & (~r_out_valid | out_ready);

  // Scan from the pointer upward (mod NUM_IN); iterating from the far end lets the
  // nearest valid channel overwrite the result last and win.
  always_comb begin
    w_rr_vld   = 1'b0;
    w_rr_idx   = '0;
    w_scan_idx = '0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
      if (w_scan_idx >= LP_N) w_scan_idx = w_scan_idx - LP_N;
      if (in_valid[w_scan_idx[SEL_W-1:0]]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = w_scan_idx[SEL_W-1:0];
      end
    end
  end

  // One-hot candidate per channel. An out-of-range sel matches no lane, so it
  // yields neither a ready nor a grant.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    assign w_pick_sel[k] = (sel == SEL_W'(k));
    assign w_pick_rr[k]  = w_rr_vld && (w_rr_idx == SEL_W'(k));
  end

  assign w_pick    = (MODE == 0) ? w_pick_sel : w_pick_rr;
  assign w_gnt_idx = (MODE == 0) ? sel : w_rr_idx;
  assign w_gnt_vld = |(w_pick & in_valid);
  assign w_xfer    = w_gnt_vld & w_can_accept;

  // In select mode the addressed channel sees ready even without valid.
  assign in_ready = {NUM_IN{w_can_accept}} & w_pick;

  // AND-OR mux keyed by the one-hot pick; never indexes past NUM_IN.
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (w_pick[k]) w_mux_data = w_mux_data | w_ch[k];
  end

  assign w_ptr_inc = {1'b0, w_gnt_idx} + LP_ONE;
  assign w_ptr_nxt = (w_ptr_inc == LP_N) ? '0 : w_ptr_inc[SEL_W-1:0];

  // Output stage: refill on transfer, drop valid on a drain with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_mux_data;
      r_out_src   <= w_gnt_idx;
      r_out_valid <= 1'b1;
      if (MODE == 1) r_rr_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: directed scenarios on three configurations, then a randomized
// run of the 3-input select mux and 4-input round-robin mux against a queue-free model.
module tb_mux_pipe_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // a: MODE=0, NUM_IN=2
  logic [9:0] a_din;  logic [1:0] a_vin, a_rdy; logic [0:0] a_sel, a_src;
  logic [4:0] a_dout; logic a_vout, a_ordy;
  // b: MODE=0, NUM_IN=3 (sel=3 out of range)
  logic [14:0] b_din; logic [2:0] b_vin, b_rdy; logic [1:0] b_sel, b_src;
  logic [4:0] b_dout; logic b_vout, b_ordy;
  // c: MODE=1, NUM_IN=4
  logic [19:0] c_din; logic [3:0] c_vin, c_rdy; logic [1:0] c_sel, c_src;
  logic [4:0] c_dout; logic c_vout, c_ordy;

  mux_pipe_n #(.WIDTH(5), .NUM_IN(2), .SEL_W(1), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_din), .in_valid(a_vin), .in_ready(a_rdy),
    .sel(a_sel), .out_data(a_dout), .out_src(a_src), .out_valid(a_vout), .out_ready(a_ordy));
  mux_pipe_n #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_din), .in_valid(b_vin), .in_ready(b_rdy),
    .sel(b_sel), .out_data(b_dout), .out_src(b_src), .out_valid(b_vout), .out_ready(b_ordy));
  mux_pipe_n #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_din), .in_valid(c_vin), .in_ready(c_rdy),
    .sel(c_sel), .out_data(c_dout), .out_src(c_src), .out_valid(c_vout), .out_ready(c_ordy));

  // reference model state
  logic       b_mv, c_mv, b_can, c_can, b_gnt;
  logic [4:0] b_md, c_md;
  logic [1:0] b_ms, c_ms;
  logic [2:0] e_b;
  logic [3:0] e_c;
  int         c_mp, c_g;
  int         seq4 [5] = '{0, 1, 2, 3, 0};
  int         seq2 [3] = '{1, 3, 1};

  initial begin
    a_din = '0; a_vin = 2'b11; a_sel = 1'b0; a_ordy = 1'b1;
    b_din = '0; b_vin = 3'b111; b_sel = 2'd0; b_ordy = 1'b1;
    c_din = '0; c_vin = 4'hf; c_sel = 2'd0; c_ordy = 1'b1;

    // reset state
    #1;
    chk("rst_a_vout", a_vout, 0); chk("rst_a_dout", a_dout, 0); chk("rst_a_src", a_src, 0);
    chk("rst_a_rdy", a_rdy, 0);   chk("rst_b_rdy", b_rdy, 0);   chk("rst_c_rdy", c_rdy, 0);
    chk("rst_c_vout", c_vout, 0);

    // 1: explicit select, both channels valid
    @(negedge clk);
    a_din = {5'b10001, 5'b01110}; c_vin = 4'h0; b_vin = 3'b000;
    rst_n = 1'b1;
    #1 chk("t1_rdy_sel0", a_rdy, 2'b01);
    step; chk("t1_d0", a_dout, 5'b01110); chk("t1_s0", a_src, 0); chk("t1_v0", a_vout, 1);
    a_sel = 1'b1;
    step; chk("t1_d1", a_dout, 5'b10001); chk("t1_s1", a_src, 1);
    a_din = {5'b01110, 5'b10001}; a_sel = 1'b0;
    step; chk("t1_swap_d0", a_dout, 5'b10001); chk("t1_swap_s0", a_src, 0);
    a_sel = 1'b1;
    step; chk("t1_swap_d1", a_dout, 5'b01110); chk("t1_swap_s1", a_src, 1);

    // 2: backpressure holds the registered beat
    a_din = {5'b00000, 5'b01110}; a_sel = 1'b0;
    step; chk("t2_d", a_dout, 5'b01110);
    a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_sel = 1'(i); a_din = {5'(i + 3), 5'(i + 20)};
      #1 chk("t2_stall_rdy", a_rdy, 2'b00);
      step;
      chk("t2_stall_d", a_dout, 5'b01110); chk("t2_stall_v", a_vout, 1); chk("t2_stall_s", a_src, 0);
    end
    a_ordy = 1'b1; a_sel = 1'b1; a_din = {5'b11111, 5'b00000};
    #1 chk("t2_rel_rdy", a_rdy, 2'b10);
    step; chk("t2_rel_d", a_dout, 5'b11111); chk("t2_rel_s", a_src, 1);

    // 3: back-to-back throughput on channel 1
    for (int v = 1; v <= 3; v++) begin
      a_din = {5'(v), 5'b00000};
      step; chk("t3_d", a_dout, v); chk("t3_v", a_vout, 1);
    end
    a_vin = 2'b00;
    step; chk("t3_drain_v", a_vout, 0); chk("t3_hold_d", a_dout, 5'd3);

    // 4: round-robin, all valid then channels 1 and 3
    c_din = {5'd13, 5'd12, 5'd11, 5'd10}; c_vin = 4'hf; c_ordy = 1'b1;
    foreach (seq4[i]) begin
      step; chk("t4_src", c_src, seq4[i]); chk("t4_d", c_dout, 10 + seq4[i]);
    end
    c_vin = 4'b1010;
    foreach (seq2[i]) begin
      step; chk("t4_alt_src", c_src, seq2[i]);
    end

    // 5: stall after out_src=2 leaves the pointer at 3
    c_vin = 4'hf;
    step; chk("t5_src2", c_src, 2);
    c_ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_stall_rdy", c_rdy, 4'b0000);
      step; chk("t5_stall_src", c_src, 2); chk("t5_stall_v", c_vout, 1);
    end
    c_ordy = 1'b1;
    #1 chk("t5_rel_rdy", c_rdy, 4'b1000);
    step; chk("t5_src3", c_src, 3);

    // 6: asynchronous reset while stalled
    c_ordy = 1'b0;
    step; chk("t6_pre_v", c_vout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_v", c_vout, 0); chk("t6_d", c_dout, 0); chk("t6_s", c_src, 0); chk("t6_rdy", c_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1; c_ordy = 1'b1;
    #1 chk("t6_first_rdy", c_rdy, 4'b0001);
    step; chk("t6_first_src", c_src, 0); chk("t6_first_v", c_vout, 1);

    // randomized phase against the model
    rst_n = 1'b0; b_vin = '0; c_vin = '0;
    step;
    rst_n = 1'b1;
    b_mv = 1'b0; b_md = '0; b_ms = '0;
    c_mv = 1'b0; c_md = '0; c_ms = '0; c_mp = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      chk("rnd_b_v", b_vout, b_mv); chk("rnd_b_d", b_dout, b_md); chk("rnd_b_s", b_src, b_ms);
      chk("rnd_c_v", c_vout, c_mv); chk("rnd_c_d", c_dout, c_md); chk("rnd_c_s", c_src, c_ms);
      b_din = 15'($urandom); b_vin = 3'($urandom_range(0, 7));
      b_sel = 2'($urandom_range(0, 3)); b_ordy = ($urandom_range(0, 3) != 0);
      c_din = 20'($urandom); c_vin = 4'($urandom_range(0, 15));
      c_ordy = ($urandom_range(0, 3) != 0);
      #1;
      // select mux: sel 3 addresses nothing
      b_can = !b_mv || b_ordy;
      e_b = 3'b000; b_gnt = 1'b0;
      if (b_sel < 3) begin
        e_b = b_can ? 3'(1 << b_sel) : 3'b000;
        b_gnt = b_vin[b_sel];
      end
      chk("rnd_b_rdy", b_rdy, e_b);
      if (b_gnt && b_can) begin
        b_mv = 1'b1; b_md = b_din[b_sel*5 +: 5]; b_ms = b_sel;
      end else if (b_ordy) b_mv = 1'b0;
      // round-robin: first valid at or after the pointer, mod 4
      c_can = !c_mv || c_ordy;
      c_g = -1;
      for (int i = 0; i < 4; i++)
        if (c_g < 0 && c_vin[(c_mp + i) % 4]) c_g = (c_mp + i) % 4;
      e_c = (c_g >= 0 && c_can) ? 4'(1 << c_g) : 4'b0000;
      chk("rnd_c_rdy", c_rdy, e_c);
      if (c_g >= 0 && c_can) begin
        c_mv = 1'b1; c_md = c_din[c_g*5 +: 5]; c_ms = 2'(c_g); c_mp = (c_g + 1) % 4;
      end else if (c_ordy) c_mv = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
